// File: rtl/imem_loader_pkg.sv
// imem_loader shared types and constants.
// State encoding, header/word sizes and the text base address.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    HDR_HI,
    HDR_LO,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

  localparam logic [31:0] TEXT_BASE = 32'h0000_3000;

  // Word index k lives at PC TEXT_BASE + 4k.
  function automatic logic [31:0] word_pc(input logic [31:0] idx);
    return TEXT_BASE + (idx << 2);
  endfunction

endpackage

// File: rtl/word_packer.sv
// word_packer: gathers four accepted bytes MSB first into a 32-bit word.
// word_valid pulses for one cycle after the fourth byte is taken.
module word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        take,
  input  logic [7:0]  data,
  output logic        last_lane,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  lane;
  logic [23:0] sh;

  assign last_lane = (lane == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      lane       <= 2'd0;
      sh         <= 24'd0;
      word       <= 32'd0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= take && last_lane;
      if (take) begin
        lane <= lane + 2'd1;
        sh   <= {sh[15:0], data};
        if (last_lane)
          word <= {sh, data};
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time byte-stream writer for the instruction memory.
// Define IMEM_CSUM_EN to require a trailing XOR checksum byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_cnt
);

  localparam logic [16:0] CAP = 17'(1) << ADDR_W;

  state_t      state;
  state_t      state_nx;
  logic [7:0]  hdr_hi;
  logic [15:0] n_words;
  logic [15:0] n_next;
  logic        accept;
  logic        take;
  logic        last_lane;
  logic        last_word;
  logic        tmo;

  assign in_ready  = (state == HDR_HI) || (state == HDR_LO) ||
                     (state == DATA)   || (state == CSUM);
  assign accept    = in_valid && in_ready;
  assign take      = accept && (state == DATA);
  assign n_next    = {hdr_hi, in_data};
  assign last_word = (17'(word_cnt) + 17'd1) == {1'b0, n_words};

  word_packer u_pack (
    .clk        (clk),
    .reset      (reset),
    .take       (take),
    .data       (in_data),
    .last_lane  (last_lane),
    .word_valid (im_we),
    .word       (im_wdata)
  );

`ifdef IMEM_CSUM_EN
  logic [7:0] csum;

  always_ff @(posedge clk) begin
    if (reset)
      csum <= 8'd0;
    else if (accept && state != CSUM)
      csum <= csum ^ in_data;
  end
`endif

  generate
    if (TIMEOUT_CYC > 0) begin : g_tmo
      logic [31:0] tcnt;
      logic        run;

      assign run = (state == HDR_LO) || (state == DATA) ||
                   (state == CSUM);
      assign tmo = (tcnt == 32'(TIMEOUT_CYC - 1));

      always_ff @(posedge clk) begin
        if (reset || accept || !run)
          tcnt <= 32'd0;
        else
          tcnt <= tcnt + 32'd1;
      end
    end else begin : g_no_tmo
      assign tmo = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset)
      state <= HDR_HI;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      HDR_HI: begin
        if (accept)
          state_nx = HDR_LO;
      end
      HDR_LO: begin
        if (accept) begin
          if (n_next == 16'd0)
`ifdef IMEM_CSUM_EN
            state_nx = CSUM;
`else
            state_nx = DONE;
`endif
          else if ({1'b0, n_next} > CAP)
            state_nx = ERR;
          else
            state_nx = DATA;
        end else if (tmo) begin
          state_nx = ERR;
        end
      end
      DATA: begin
        if (take && last_lane && last_word)
`ifdef IMEM_CSUM_EN
          state_nx = CSUM;
`else
          state_nx = DONE;
`endif
        else if (!accept && tmo)
          state_nx = ERR;
      end
`ifdef IMEM_CSUM_EN
      CSUM: begin
        if (accept)
          state_nx = (in_data == csum) ? DONE : ERR;
        else if (tmo)
          state_nx = ERR;
      end
`endif
      DONE: state_nx = DONE;
      ERR:  state_nx = ERR;
      default: state_nx = ERR;
    endcase
  end

  // Status flags follow the state by one cycle so done trails the last write.
  always_ff @(posedge clk) begin
    if (reset) begin
      hdr_hi   <= 8'd0;
      n_words  <= 16'd0;
      word_cnt <= '0;
      im_addr  <= '0;
      done     <= 1'b0;
      error    <= 1'b0;
      cpu_hold <= 1'b1;
    end else begin
      if (accept && state == HDR_HI)
        hdr_hi <= in_data;
      if (accept && state == HDR_LO)
        n_words <= n_next;
      if (take && last_lane) begin
        im_addr  <= word_cnt[ADDR_W-1:0];
        word_cnt <= word_cnt + {{ADDR_W{1'b0}}, 1'b1};
      end
      done     <= (state == DONE);
      error    <= (state == ERR);
      cpu_hold <= (state != DONE);
    end
  end

endmodule
